// File: rtl/rapcore_spi_host.sv
`default_nettype none
// ============================================================================
// Module      : rapcore_spi_host
// Description : Wishbone-controlled SPI mode-0 host issuing 32-bit words to
//               the rapcore responder. Optional interrupt output is enabled
//               by defining RAPCORE_SPI_HOST_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rapcore_spi_host #(
    parameter int DIV_BITS = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        spi_sck_o,
    output logic        spi_cs_o,
    output logic        spi_copi_o,
    input  logic        spi_cipo_i,
    output logic        irq_o
);

    localparam logic [1:0] c_ADR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADR_STATUS = 2'd1;
    localparam logic [1:0] c_ADR_TXDATA = 2'd2;
    localparam logic [1:0] c_ADR_RXDATA = 2'd3;
    localparam logic [5:0] c_WORD_BITS  = 6'd32;

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_SETUP = 2'd1,
        c_HIGH  = 2'd2,
        c_LOW   = 2'd3
    } state_t;

    // Bus-side registers
    logic                r_ack;
    logic [31:0]         r_dat;
    logic [DIV_BITS-1:0] r_clkdiv;
    logic                r_cs_hold;
    logic                r_rx_valid;
    logic                r_overrun;
    logic [31:0]         r_rxdata;

    // Transfer engine registers and their next values
    state_t              r_state,  w_state_nxt;
    logic [DIV_BITS-1:0] r_cnt,    w_cnt_nxt;
    logic [DIV_BITS-1:0] r_div,    w_div_nxt;
    logic [5:0]          r_bits,   w_bits_nxt;
    logic [31:0]         r_tx,     w_tx_nxt;
    logic [31:0]         r_rx,     w_rx_nxt;
    logic                r_cs,     w_cs_nxt;
    logic                r_sck,    w_sck_nxt;
    logic                w_done;

    logic        w_req, w_wr, w_rd;
    logic        w_ctrl_wr, w_stat_wr, w_tx_start, w_rx_rd;
    logic        w_cs_hold_nxt;
    logic        w_busy;
    logic        w_irq_en;
    logic [31:0] w_ctrl;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_req      = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_wr       = w_req & wbs_we_i;
    assign w_rd       = w_req & ~wbs_we_i;
    assign w_ctrl_wr  = w_wr & (wbs_adr_i[3:2] == c_ADR_CTRL);
    assign w_stat_wr  = w_wr & (wbs_adr_i[3:2] == c_ADR_STATUS);
    assign w_rx_rd    = w_rd & (wbs_adr_i[3:2] == c_ADR_RXDATA);
    assign w_busy     = (r_state != c_IDLE);
    assign w_tx_start = w_wr & (wbs_adr_i[3:2] == c_ADR_TXDATA) & ~w_busy;

    assign w_cs_hold_nxt = (w_ctrl_wr && wbs_sel_i[1]) ? wbs_dat_i[8] : r_cs_hold;

    assign w_unused = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:2]};

    always_comb begin
        w_ctrl              = '0;
        w_ctrl[DIV_BITS-1:0] = r_clkdiv;
        w_ctrl[8]           = r_cs_hold;
        w_ctrl[9]           = w_irq_en;
        w_rdata             = '0;
        case (wbs_adr_i[3:2])
            c_ADR_CTRL:   w_rdata = w_ctrl;
            c_ADR_STATUS: w_rdata = {29'd0, r_overrun, r_rx_valid, w_busy};
            c_ADR_RXDATA: w_rdata = r_rxdata;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_clkdiv   <= '0;
            r_cs_hold  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_rxdata   <= '0;
        end else begin
            r_ack     <= w_req;
            r_dat     <= w_rd ? w_rdata : 32'd0;
            r_cs_hold <= w_cs_hold_nxt;
            if (w_ctrl_wr && wbs_sel_i[0]) begin
                r_clkdiv <= wbs_dat_i[DIV_BITS-1:0];
            end
            if (w_done) begin
                r_rxdata <= r_rx;
            end
            // Completion beats a same-cycle RXDATA read, and that read
            // suppresses the overrun it would otherwise cause.
            if (w_done) begin
                r_rx_valid <= 1'b1;
            end else if (w_rx_rd) begin
                r_rx_valid <= 1'b0;
            end
            if (w_done && r_rx_valid && !w_rx_rd) begin
                r_overrun <= 1'b1;
            end else if (w_stat_wr && wbs_dat_i[2]) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_bits  <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_cs    <= 1'b1;
            r_sck   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
            r_bits  <= w_bits_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_cs    <= w_cs_nxt;
            r_sck   <= w_sck_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_bits_nxt  = r_bits;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_cs_nxt    = r_cs;
        w_sck_nxt   = r_sck;
        w_done      = 1'b0;
        unique case (r_state)
            c_IDLE: begin
                w_sck_nxt = 1'b0;
                // Idle CS only ever releases; it asserts solely with a transfer.
                w_cs_nxt  = r_cs | ~w_cs_hold_nxt;
                if (w_tx_start) begin
                    w_state_nxt = c_SETUP;
                    w_cnt_nxt   = r_clkdiv;
                    w_div_nxt   = r_clkdiv;
                    w_tx_nxt    = wbs_dat_i;
                    w_bits_nxt  = '0;
                    w_cs_nxt    = 1'b0;
                end
            end
            c_SETUP, c_LOW: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (r_state == c_LOW && r_bits == c_WORD_BITS) begin
                    w_state_nxt = c_IDLE;
                    w_cs_nxt    = ~r_cs_hold;
                    w_done      = 1'b1;
                end else begin
                    w_state_nxt = c_HIGH;
                    w_cnt_nxt   = r_div;
                    w_sck_nxt   = 1'b1;
                    w_rx_nxt    = {r_rx[30:0], spi_cipo_i};
                    w_bits_nxt  = r_bits + 6'd1;
                end
            end
            c_HIGH: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = c_LOW;
                    w_cnt_nxt   = r_div;
                    w_sck_nxt   = 1'b0;
                    w_tx_nxt    = {r_tx[30:0], 1'b0};
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

`ifdef RAPCORE_SPI_HOST_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr && wbs_sel_i[1]) begin
                r_irq_en <= wbs_dat_i[9];
            end
            r_irq <= r_irq_en & r_rx_valid;
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq_o    = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign irq_o    = 1'b0;
`endif

    assign wbs_ack_o  = r_ack;
    assign wbs_dat_o  = r_dat;
    assign spi_sck_o  = r_sck;
    assign spi_cs_o   = r_cs;
    assign spi_copi_o = r_tx[31];

endmodule
`default_nettype wire

// File: tb/tb_rapcore_spi_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_rapcore_spi_host
// Description : Randomized self-checking bench for rapcore_spi_host with a
//               word-level SPI responder and register-flag reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rapcore_spi_host;

    localparam logic [1:0] R_CTRL   = 2'd0;
    localparam logic [1:0] R_STATUS = 2'd1;
    localparam logic [1:0] R_TXDATA = 2'd2;
    localparam logic [1:0] R_RXDATA = 2'd3;

    logic        wb_clk_i   = 1'b0;
    logic        wb_rst_i   = 1'b1;
    logic        wbs_stb_i  = 1'b0;
    logic        wbs_cyc_i  = 1'b0;
    logic        wbs_we_i   = 1'b0;
    logic [3:0]  wbs_sel_i  = 4'h0;
    logic [31:0] wbs_adr_i  = 32'd0;
    logic [31:0] wbs_dat_i  = 32'd0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        spi_sck_o;
    logic        spi_cs_o;
    logic        spi_copi_o;
    logic        spi_cipo_i = 1'b0;
    logic        irq_o;

    always #5 wb_clk_i = ~wb_clk_i;

    rapcore_spi_host #(.DIV_BITS(8)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .spi_sck_o  (spi_sck_o),
        .spi_cs_o   (spi_cs_o),
        .spi_copi_o (spi_copi_o),
        .spi_cipo_i (spi_cipo_i),
        .irq_o      (irq_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Word-level responder: shifts out resp_q MSB first, reloading every 32 bits
    logic [31:0] resp_q = 32'd0;
    logic [31:0] resp_sh = 32'd0;
    int          resp_cnt = 0;
    logic        resp_prev_cs = 1'b1;

    always @(spi_cs_o or negedge spi_sck_o) begin
        if (resp_prev_cs && !spi_cs_o) begin
            resp_sh    = resp_q;
            resp_cnt   = 0;
            spi_cipo_i = resp_sh[31];
        end else if (!spi_cs_o && !spi_sck_o) begin
            resp_cnt++;
            if (resp_cnt == 32) begin
                resp_cnt = 0;
                resp_sh  = resp_q;
            end else begin
                resp_sh = {resp_sh[30:0], 1'b0};
            end
            spi_cipo_i = resp_sh[31];
        end
        resp_prev_cs = spi_cs_o;
    end

    // Pin monitor, sampled mid-cycle
    int          pulses = 0, cs_cycles = 0, cs_len = 0, cs_rises = 0;
    int          hi_len = 0, hi_min = 1000, hi_max = 0;
    logic [31:0] copi_word = 32'd0;
    logic        prev_sck = 1'b0, prev_cs = 1'b1, irq_seen = 1'b0;

    always @(negedge wb_clk_i) begin
        if (spi_sck_o && !prev_sck) begin
            pulses++;
            copi_word = {copi_word[30:0], spi_copi_o};
        end
        if (spi_sck_o) begin
            hi_len++;
        end else if (prev_sck) begin
            if (hi_len < hi_min) hi_min = hi_len;
            if (hi_len > hi_max) hi_max = hi_len;
            hi_len = 0;
        end
        if (!spi_cs_o) begin
            cs_cycles = prev_cs ? 1 : cs_cycles + 1;
        end else if (!prev_cs) begin
            cs_len = cs_cycles;
            cs_rises++;
        end
        if (irq_o) irq_seen = 1'b1;
        prev_sck = spi_sck_o;
        prev_cs  = spi_cs_o;
    end

    task automatic clr_mon();
        pulses    = 0;
        cs_len    = 0;
        cs_rises  = 0;
        hi_len    = 0;
        hi_min    = 1000;
        hi_max    = 0;
        copi_word = 32'd0;
    endtask

    task automatic settle();
        @(negedge wb_clk_i);
        #1;
    endtask

    task automatic wb_write(input logic [1:0] ridx, input logic [31:0] data, input logic [3:0] sel);
        int k;
        @(posedge wb_clk_i);
        #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = {28'd0, ridx, 2'b00}; wbs_dat_i = data; wbs_sel_i = sel;
        k = 0;
        do begin
            @(posedge wb_clk_i);
            #1;
            k++;
        end while (!wbs_ack_o && k < 8);
        if (!wbs_ack_o) check("wb_write_ack_timeout", 32'd0, 32'd1);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] ridx, output logic [31:0] data);
        int k;
        @(posedge wb_clk_i);
        #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
        wbs_adr_i = {28'd0, ridx, 2'b00}; wbs_sel_i = 4'hF;
        k = 0;
        do begin
            @(posedge wb_clk_i);
            #1;
            k++;
        end while (!wbs_ack_o && k < 8);
        if (!wbs_ack_o) check("wb_read_ack_timeout", 32'd0, 32'd1);
        data = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic wait_cs_high(input int bound);
        int k = 0;
        while (!spi_cs_o && k < bound) begin
            @(posedge wb_clk_i);
            #1;
            k++;
        end
        if (!spi_cs_o) check("cs_release_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_not_busy();
        logic [31:0] st;
        int k = 0;
        st = 32'd1;
        while (st[0] && k < 200) begin
            wb_read(R_STATUS, st);
            k++;
        end
        if (st[0]) check("busy_timeout", 32'd0, 32'd1);
    endtask

    // One full word with CS released afterwards; frame expectations come
    // from the word format: 32 pulses, 65*D cycles of CS, D-cycle SCK high.
    task automatic send_word(input logic [31:0] tx, input logic [31:0] rsp, input int d);
        clr_mon();
        resp_q = rsp;
        wb_write(R_TXDATA, tx, 4'hF);
        wait_cs_high(70 * d + 20);
        settle();
        check("pulses", 32'(pulses), 32'd32);
        check("copi_word", copi_word, tx);
        check("cs_len", 32'(cs_len), 32'(65 * d));
        check("sck_high_min", 32'(hi_min), 32'(d));
        check("sck_high_max", 32'(hi_max), 32'(d));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] tx, rsp, exp_rxdata;
        logic        exp_rxv, exp_ovr;
        int          d, act, k;

        wb_rst_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst_cs", 32'(spi_cs_o), 32'd1);
        check("rst_sck", 32'(spi_sck_o), 32'd0);
        check("rst_copi", 32'(spi_copi_o), 32'd0);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        wb_rst_i = 1'b0;
        for (int r = 0; r < 4; r++) begin
            wb_read(2'(r), rd);
            check($sformatf("rst_reg%0d", r), rd, 32'd0);
        end
        settle();
        clr_mon();

        // clkdiv=0 reference word
        resp_q = 32'h1234_5678;
        wb_write(R_TXDATA, 32'hA5C3_0F01, 4'hF);
        check("cs_at_ack", 32'(spi_cs_o), 32'd0);
        wb_read(R_STATUS, rd);
        check("status_busy", rd, 32'h1);
        wait_cs_high(200);
        settle();
        check("d0_pulses", 32'(pulses), 32'd32);
        check("d0_copi", copi_word, 32'hA5C3_0F01);
        check("d0_cs_len", 32'(cs_len), 32'd65);
        check("d0_sck_high", 32'(hi_max), 32'd1);
        wb_read(R_STATUS, rd);
        check("d0_status", rd, 32'h2);
        wb_read(R_RXDATA, rd);
        check("d0_rxdata", rd, 32'h1234_5678);
        wb_read(R_STATUS, rd);
        check("d0_status_after_read", rd, 32'h0);

        // clkdiv=3 with a dropped write mid-transfer
        wb_write(R_CTRL, 32'd3, 4'h1);
        clr_mon();
        resp_q = 32'hC0FF_EE11;
        wb_write(R_TXDATA, 32'h3C5A_96E1, 4'hF);
        repeat (40) @(posedge wb_clk_i);
        wb_write(R_TXDATA, 32'hFFFF_FFFF, 4'hF);
        wait_cs_high(400);
        settle();
        check("d3_pulses", 32'(pulses), 32'd32);
        check("d3_copi", copi_word, 32'h3C5A_96E1);
        check("d3_cs_len", 32'(cs_len), 32'd260);
        check("d3_sck_high_min", 32'(hi_min), 32'd4);
        check("d3_sck_high_max", 32'(hi_max), 32'd4);
        repeat (20) @(posedge wb_clk_i);
        #1;
        check("d3_no_second_word", 32'(pulses), 32'd32);
        check("d3_cs_idle", 32'(spi_cs_o), 32'd1);
        wb_read(R_RXDATA, rd);
        check("d3_rxdata", rd, 32'hC0FF_EE11);

        // Overrun: two words without reading RXDATA
        wb_write(R_CTRL, 32'd0, 4'h3);
        send_word(32'h0102_0304, 32'hAAAA_0001, 1);
        send_word(32'h8070_6050, 32'h5555_0002, 1);
        wb_read(R_STATUS, rd);
        check("ovr_status", rd, 32'h6);
        wb_read(R_RXDATA, rd);
        check("ovr_rxdata", rd, 32'h5555_0002);
        wb_write(R_STATUS, 32'h4, 4'hF);
        wb_read(R_STATUS, rd);
        check("ovr_cleared", rd, 32'h0);

        // cs_hold across two back-to-back words
        wb_write(R_CTRL, 32'h100, 4'h3);
        check("hold_no_assert", 32'(spi_cs_o), 32'd1);
        clr_mon();
        resp_q = 32'hDEAD_0001;
        wb_write(R_TXDATA, 32'h1357_9BDF, 4'hF);
        resp_q = 32'hBEEF_0002;
        wait_not_busy();
        check("hold_w1_pulses", 32'(pulses), 32'd32);
        check("hold_w1_copi", copi_word, 32'h1357_9BDF);
        check("hold_w1_cs_low", 32'(spi_cs_o), 32'd0);
        wb_read(R_RXDATA, rd);
        check("hold_w1_rxdata", rd, 32'hDEAD_0001);
        clr_mon();
        wb_write(R_TXDATA, 32'h2468_ACE0, 4'hF);
        wait_not_busy();
        check("hold_w2_pulses", 32'(pulses), 32'd32);
        check("hold_w2_copi", copi_word, 32'h2468_ACE0);
        check("hold_cs_rises", 32'(cs_rises), 32'd0);
        check("hold_w2_cs_low", 32'(spi_cs_o), 32'd0);
        wb_read(R_RXDATA, rd);
        check("hold_w2_rxdata", rd, 32'hBEEF_0002);
        wb_write(R_CTRL, 32'h0, 4'h3);
        check("hold_release", 32'(spi_cs_o), 32'd1);

        // Interrupt behaviour
`ifdef RAPCORE_SPI_HOST_IRQ_EN
        wb_write(R_CTRL, 32'h200, 4'h3);
        wb_read(R_CTRL, rd);
        check("irq_ctrl_readback", rd, 32'h200);
        resp_q = 32'h0BAD_F00D;
        wb_write(R_TXDATA, 32'h7777_8888, 4'hF);
        wait_cs_high(200);
        check("irq_not_yet", 32'(irq_o), 32'd0);
        @(posedge wb_clk_i);
        #1;
        check("irq_rise", 32'(irq_o), 32'd1);
        wb_read(R_RXDATA, rd);
        check("irq_rxdata", rd, 32'h0BAD_F00D);
        @(posedge wb_clk_i);
        #1;
        check("irq_fall", 32'(irq_o), 32'd0);
`else
        wb_write(R_CTRL, 32'h200, 4'h3);
        wb_read(R_CTRL, rd);
        check("irq_ctrl_readback", rd, 32'h0);
        send_word(32'h7777_8888, 32'h0BAD_F00D, 1);
        @(posedge wb_clk_i);
        #1;
        check("irq_tied_low", 32'(irq_o), 32'd0);
        wb_read(R_RXDATA, rd);
        check("irq_rxdata", rd, 32'h0BAD_F00D);
`endif
        wb_write(R_CTRL, 32'h0, 4'h3);

        // Randomized words against the flag model
        wb_write(R_STATUS, 32'h4, 4'hF);
        wb_read(R_STATUS, rd);
        check("rand_pre_status", rd, 32'h0);
        exp_rxv    = 1'b0;
        exp_ovr    = 1'b0;
        exp_rxdata = 32'd0;
        for (int i = 0; i < 10; i++) begin
            d   = $urandom_range(0, 3);
            tx  = $urandom;
            rsp = $urandom;
            wb_write(R_CTRL, 32'(d), 4'h1);
            send_word(tx, rsp, d + 1);
            if (exp_rxv) exp_ovr = 1'b1;
            exp_rxv    = 1'b1;
            exp_rxdata = rsp;
            act = $urandom_range(0, 3);
            if (act % 2 == 1) begin
                wb_read(R_STATUS, rd);
                check("rand_status", rd, {29'd0, exp_ovr, exp_rxv, 1'b0});
            end
            if (act >= 2) begin
                wb_read(R_RXDATA, rd);
                check("rand_rxdata", rd, exp_rxdata);
                exp_rxv = 1'b0;
            end
            if (act == 0 && $urandom_range(0, 1) == 1) begin
                wb_write(R_STATUS, 32'h4, 4'hF);
                exp_ovr = 1'b0;
            end
        end
        wb_read(R_STATUS, rd);
        check("rand_final_status", rd, {29'd0, exp_ovr, exp_rxv, 1'b0});

        // Reset during pulse 10
        wb_write(R_CTRL, 32'd2, 4'h1);
        clr_mon();
        resp_q = $urandom;
        wb_write(R_TXDATA, $urandom, 4'hF);
        k = 0;
        while (pulses < 10 && k < 500) begin
            settle();
            k++;
        end
        if (pulses < 10) check("rst_mid_wait_timeout", 32'd0, 32'd1);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        check("rst_mid_cs", 32'(spi_cs_o), 32'd1);
        check("rst_mid_sck", 32'(spi_sck_o), 32'd0);
        wb_rst_i = 1'b0;
        wb_read(R_STATUS, rd);
        check("rst_mid_status", rd, 32'h0);
        wb_read(R_CTRL, rd);
        check("rst_mid_ctrl", rd, 32'h0);

`ifndef RAPCORE_SPI_HOST_IRQ_EN
        check("irq_never_seen", 32'(irq_seen), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rapcore_spi_host.md
# rapcore_spi_host

Wishbone-controlled SPI host (controller) that drives the SCK/CS/COPI lines and samples CIPO of the rapcore motion controller's SPI responder. It lets the management SoC issue 32-bit SPI words to rapcore directly over the user-area Wishbone bus. It sits beside the rapcore instance in the user project, and its SPI pins connect to rapcore's SPI inputs and CIPO output.

## Interface
- DIV_BITS, 8, width of the SCK half-period divider field
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_stb_i / wbs_cyc_i  in  1 each  Wishbone strobe / cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  address; only [3:2] decoded
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- spi_sck_o  out  1  SPI clock, mode 0 (idle low)
- spi_cs_o  out  1  chip select, active-low
- spi_copi_o  out  1  controller-out data
- spi_cipo_i  in  1  controller-in data
- irq_o  out  1  level interrupt, word received

## Operation
- Register map (adr[3:2]): 0 CTRL = [DIV_BITS-1:0] clkdiv, [8] cs_hold, [9] irq_en. 1 STATUS (RO except W1C) = [0] busy, [1] rx_valid, [2] overrun (W1C). 2 TXDATA (WO; reads 0). 3 RXDATA (RO; read clears rx_valid).
- CTRL writes honour wbs_sel_i[0] (clkdiv) and wbs_sel_i[1] (bits 9:8). TXDATA write ignores sel and takes all 32 bits.
- Request accepted when cyc&&stb&&!ack. ack is registered, high exactly one cycle. wbs_dat_o is valid in the ack cycle and 0 otherwise.
- Writing TXDATA while idle starts a transfer. The clkdiv value is latched at start. Writing TXDATA while busy is acked and dropped.
- Word frame: 32 bits, MSB first, mode 0. COPI changes on SCK falling edge, or at CS assertion for bit 31. CIPO is sampled on the cycle SCK rises.
- FSM: IDLE -> SETUP -> HIGH <-> LOW -> IDLE.
  - SETUP: CS low, SCK low, COPI=bit31, held D=clkdiv+1 cycles.
  - HIGH: SCK high for D cycles; CIPO shifted into the RX register on entry.
  - LOW: SCK low for D cycles; next COPI bit presented on entry.
  - After the 32nd HIGH, the final LOW (D cycles) returns to IDLE.
- On return to IDLE: RXDATA is loaded, busy clears, and rx_valid sets. If rx_valid was already 1, overrun sets (sticky) and RXDATA is overwritten. CS deasserts unless cs_hold=1.
- cs_hold=1 keeps CS low across words; clearing it while idle deasserts CS the next cycle. With CS already low, SETUP still lasts D cycles.
- Simultaneous RXDATA read and word completion: the completion wins, rx_valid stays 1, and no overrun is flagged.

## Timing
- Reset values: sck 0, cs 1, copi 0, ack 0, dat_o 0, irq_o 0. All registers are 0 and the FSM is IDLE.
- Reset mid-transfer aborts the transfer; CS goes high and SCK low at the first clock edge with wb_rst_i high.
- TXDATA ack at cycle T+1 (accept at T). CS asserts and busy=1 at T+1.
- CS assert to busy clear takes 65·D cycles. With clkdiv=0 (D=1), that is 65 cycles and SCK = wb_clk_i/2.
- STATUS reflects busy in the same cycle that CS asserts.

## Configuration
- RAPCORE_SPI_HOST_IRQ_EN defined: irq_o = irq_en & rx_valid, registered (one cycle after rx_valid sets).
- Not defined: irq_o is tied 0, CTRL[9] reads 0, and writes to it are ignored.

## Test plan
- Reset, then read all four registers: CTRL=0, STATUS=0, TXDATA=0, RXDATA=0. Pins are cs=1, sck=0.
- clkdiv=0. Write TXDATA=0xA5C3_0F01 with a responder model returning 0x1234_5678. Required response: 32 SCK pulses, MSB-first COPI matches, busy clears after 65 cycles, RXDATA=0x1234_5678, rx_valid=1, CS high.
- clkdiv=3. Send a word, then write TXDATA=0xFFFF_FFFF mid-transfer. Required response: SCK half-period is 4 cycles, the second write is dropped, exactly 32 pulses occur, and busy lasts 260 cycles.
- Send two words without reading RXDATA. Required response: overrun=1 and RXDATA holds the second word. Write STATUS=0x4 and overrun clears.
- cs_hold=1, two back-to-back words: CS stays low between them. Then clear cs_hold and CS goes high the next cycle. Assert wb_rst_i at pulse 10 of a word: CS high and SCK low after one edge, STATUS=0.
- With RAPCORE_SPI_HOST_IRQ_EN defined and irq_en=1: irq_o rises one cycle after rx_valid and falls after an RXDATA read. With the macro undefined, irq_o stays 0.
